// File: rtl/edg_pkg.sv
// Shared definitions for the two-pixel edge-detection frame scheduler.
//   - scheduler state encoding
//   - pixel and pixel-pair widths (RGB666, two pixels per word)
//   - default frame geometry (640x480 as 320 pairs x 480 lines)
//   - is_active(): true while a frame occupies the datapath
package edg_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int PIX_W  = 18;
    localparam int PAIR_W = 2 * PIX_W;

    localparam int H_PAIRS_DEF = 320;
    localparam int V_LINES_DEF = 480;

    function automatic logic is_active(input state_t s);
        return (s == S_RUN) || (s == S_DRAIN);
    endfunction

endpackage

// File: rtl/edg_tag_pipe.sv
// LAT-deep shift register of {valid, addr} tags that follows each issued
// pixel pair through the fixed-latency edge datapath.
//   clk, reset  : clock, synchronous active-high reset
//   flush       : synchronous clear of every valid bit (abort)
//   push        : a pair is issued this cycle; push_addr is its address
//   out_valid   : tag in the last stage is valid (result on dp_result now)
//   out_addr    : address carried by the last-stage tag
//   empty       : no valid tag in any stage
module edg_tag_pipe #(
    parameter int LAT    = 4,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic              empty
);

    logic [LAT-1:0]    vld;
    logic [ADDR_W-1:0] addr [LAT];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the value its neighbour held before the clock edge.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vld <= '0;
        end else begin
            vld <= {vld[LAT-2:0], push};
        end
    end

    // NOTE: the address stages carry no reset; they are only observed when
    // the matching valid bit is set, and valids are reset above.
    always_ff @(posedge clk) begin
        addr[0] <= push_addr;
        for (int i = 1; i < LAT; i++) begin
            addr[i] <= addr[i-1];
        end
    end

    assign out_valid = vld[LAT-1];
    assign out_addr  = addr[LAT-1];
    assign empty     = ~|vld;

endmodule

// File: rtl/edg_frame_sched.sv
// Frame-level scheduler for the two-pixel edge-detection datapath.
// Pulls pixel pairs from the frame-buffer read side, issues one pair every
// two clocks to the datapath, tracks each through the datapath latency and
// emits write-back requests in issue order.
//   clk, reset          : clock, synchronous active-high reset
//   start, abort        : begin a frame when idle / flush the current frame
//   in_pix/valid/ready  : pixel-pair input handshake
//   dp_pix, dp_phase    : pair and phase bit presented to the datapath
//   dp_result           : processed pair, LAT clocks after issue
//   wr_en/addr/data     : write-back request for a processed pair
//   busy, done          : frame in progress / one-cycle completion pulse
//   frame_cnt           : completed frames, wraps at 255
module edg_frame_sched
    import edg_pkg::*;
#(
    parameter int H_PAIRS = H_PAIRS_DEF,
    parameter int V_LINES = V_LINES_DEF,
    parameter int LAT     = 4,
    parameter int ADDR_W  = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [PAIR_W-1:0] in_pix,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [PAIR_W-1:0] dp_pix,
    output logic              dp_phase,
    input  logic [PAIR_W-1:0] dp_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PAIR_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        frame_cnt
);

    // One extra bit so a frame filling the whole address space still counts.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  TOTAL_C  = CNT_W'(H_PAIRS * V_LINES);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(H_PAIRS * V_LINES - 1);
    localparam logic [ADDR_W-1:0] H_LAST   = ADDR_W'(H_PAIRS - 1);
    localparam logic [ADDR_W-1:0] H_STEP   = ADDR_W'(H_PAIRS);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  issued;
    logic [ADDR_W-1:0] pair;
    logic [ADDR_W-1:0] line_base;    // line * H_PAIRS, built by repeated add
    logic              active;
    logic              flush;
    logic              xfer;
    logic              last_xfer;
    logic              tag_valid;
    logic [ADDR_W-1:0] tag_addr;
    logic              tag_empty;

    assign active    = is_active(state);
    assign flush     = abort && active;
    assign in_ready  = (state == S_RUN) && !dp_phase && (issued < TOTAL_C);
    assign xfer      = in_valid && in_ready;
    assign last_xfer = xfer && (issued == LAST_IDX);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next state gets its default before the case so no path through
    // the block leaves it unassigned (which would infer a latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start && !abort) state_nxt = S_RUN;
            S_RUN:   if (abort)           state_nxt = S_IDLE;
                     else if (last_xfer)  state_nxt = S_DRAIN;
            S_DRAIN: if (abort)           state_nxt = S_IDLE;
                     else if (tag_empty)  state_nxt = S_DONE;
            S_DONE:                       state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    // Phase starts at 0 on entry to RUN and toggles while a frame is active.
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_phase <= 1'b0;
        end else if (active && is_active(state_nxt)) begin
            dp_phase <= ~dp_phase;
        end else begin
            dp_phase <= 1'b0;
        end
    end

    // ---------------- Issue counters ----------------
    always_ff @(posedge clk) begin
        if (reset || flush || (state == S_IDLE && start)) begin
            issued    <= '0;
            pair      <= '0;
            line_base <= '0;
        end else if (xfer) begin
            issued <= issued + CNT_W'(1);
            if (pair == H_LAST) begin
                pair      <= '0;
                line_base <= line_base + H_STEP;
            end else begin
                pair <= pair + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dp_pix <= '0;
        end else if (xfer) begin
            dp_pix <= in_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (state == S_DONE) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // ---------------- Tag tracking ----------------
    edg_tag_pipe #(
        .LAT    (LAT),
        .ADDR_W (ADDR_W)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (xfer),
        .push_addr (line_base + pair),
        .out_valid (tag_valid),
        .out_addr  (tag_addr),
        .empty     (tag_empty)
    );

    // Write-back fields are gated so they read 0 whenever no request is up.
    assign wr_en   = tag_valid;
    assign wr_addr = tag_valid ? tag_addr  : '0;
    assign wr_data = tag_valid ? dp_result : '0;

    assign busy = active;
    assign done = (state == S_DONE);

endmodule

// File: doc/edg_frame_sched.md
Name: edg_frame_sched

Overview:
- Frame-level scheduler for the two-pixel edge-detection datapath.
- Pulls packed 36-bit pixel pairs (2 x 18-bit RGB666) from the frame-buffer read side through a valid/ready handshake.
- Issues one pair every two clocks to the datapath and drives the datapath's phase bit.
- Tags each issued pair with its frame-buffer address, tracks it through the fixed datapath latency, and emits write-back requests for processed pairs, plus busy/done/frame-count status.

Parameters:
- H_PAIRS, 320, pixel pairs per line (640 px / 2)
- V_LINES, 480, lines per frame
- LAT, 4, clocks from a pair's issue to its processed result on dp_result; legal range 2..15
- ADDR_W, 18, write-back address width; must satisfy 2^ADDR_W >= H_PAIRS*V_LINES

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- abort  in  1  synchronous abort; flushes the current frame
- in_pix  in  36  pixel pair; [17:0] lower pixel, [35:18] upper pixel
- in_valid  in  1  in_pix valid
- in_ready  out  1  scheduler accepts in_pix this cycle
- dp_pix  out  36  pair presented to the edge datapath
- dp_phase  out  1  datapath phase bit (stands in for hcount[0])
- dp_result  in  36  processed pair from the datapath
- wr_en  out  1  write-back strobe
- wr_addr  out  ADDR_W  write-back address
- wr_data  out  36  write-back data (= dp_result)
- busy  out  1  frame in progress (RUN or DRAIN)
- done  out  1  one-cycle pulse at frame completion
- frame_cnt  out  8  completed-frame counter, wraps at 255

Behaviour:
- Reset: state IDLE; every output is 0 (in_ready, wr_en, wr_addr, wr_data, dp_pix, dp_phase, busy, done, frame_cnt); tag pipeline and counters cleared.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> DRAIN on the cycle the last pair (issue count = H_PAIRS*V_LINES) is accepted.
  - DRAIN -> DONE when the tag pipeline is empty.
  - DONE -> IDLE unconditionally after 1 cycle.
- Phase: dp_phase toggles every clock in RUN and DRAIN and is forced to 0 in IDLE/DONE. It is 0 on the first RUN cycle.
- Handshake:
  - in_ready = (state==RUN) && (dp_phase==0) && (issued < H_PAIRS*V_LINES). It is combinational on registered state.
  - Transfer occurs when in_valid && in_ready.
  - in_valid low simply skips that slot; the phase keeps toggling, so the next opportunity is 2 clocks later.
- Issue:
  - On a transfer, dp_pix <= in_pix (registered, held until the next transfer).
  - The tag {valid=1, addr=line*H_PAIRS+pair} enters the tag pipeline. It is computed from separate pair and line counters: pair wraps at H_PAIRS-1 and increments line; no multiplier.
- Tag pipeline: LAT stages of {valid, addr}, shifting every clock. When stage LAT-1 is valid, the outputs that cycle are wr_en=1, wr_addr=tag addr, wr_data=dp_result. Total latency from transfer to wr_en is LAT cycles.
- done is pulsed in the DONE state; frame_cnt increments in the same cycle.
- busy = RUN or DRAIN.
- start while not IDLE is ignored.
- start and abort in the same cycle: abort wins.
- abort in RUN or DRAIN: next state IDLE; all tag valids cleared, so no further wr_en; counters cleared; no done pulse; frame_cnt unchanged.
- abort in IDLE or DONE: no effect (a DONE pulse still completes).
- Reset mid-frame: identical to abort, and frame_cnt is also cleared.
- Write-back order equals issue order. Addresses are strictly increasing 0..H_PAIRS*V_LINES-1 with no gaps.

Decomposition:
- Shared package edg_pkg holds:
  - state encoding constants S_IDLE, S_RUN, S_DRAIN, S_DONE
  - pixel-pair width 36 and per-pixel width 18
  - default frame geometry (H_PAIRS, V_LINES)
- One natural sub-module: edg_tag_pipe, a parameterised LAT-deep {valid, addr} shift register with synchronous flush.

Test Plan:
- Reset: assert reset 3 cycles with in_valid=1 -> all outputs 0, in_ready=0; start ignored while reset high.
- Small frame (H_PAIRS=4, V_LINES=2, LAT=3), in_valid held 1, in_pix=pair index -> expected response:
  - 8 transfers on alternating cycles starting the cycle after start
  - wr_en 3 cycles after each transfer, wr_addr 0..7, wr_data = model datapath output
  - done exactly once, frame_cnt=1
- Stalls: same frame with in_valid random 50% -> still exactly 8 writes, addrs 0..7 in order, no transfer on dp_phase=1 cycles.
- Abort after 5 transfers -> at most the 5 in-flight writes already past stage LAT-1 appear, none after the abort cycle; state IDLE, done never pulses, frame_cnt unchanged; the next start gives a clean frame from addr 0.
- start pulsed during RUN and during DRAIN -> ignored; exactly 8 writes and one done.
- Back-to-back frames: start on the cycle after done, repeated 3 times -> frame_cnt = 3; each frame's writes are 0..7.
